mem_bus_arbiter4: RTL and testbench
===================================

Name: mem_bus_arbiter4

Overview:
- Round-robin arbiter sharing one memory/bus port among four requesters in the multi-cycle CPU (e.g. IF, MEM, DMA, debug).
- Grants one requester at a time and holds the grant until the memory answers with mem_ready or a timeout expires.
- Drives the 2-bit select of the address, write-data and we muxes (4:1 N-bit selects) onto the shared port.
- Broadcasts read data and returns a one-cycle ack or err strobe to the granted requester.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum BUSY cycles without mem_ready before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; held high until ack or err.
- we_in  input  4  write enable per requester.
- addr_in  input  4*AW  requester i address in bits [i*AW +: AW].
- wdata_in  input  4*DW  requester i write data in bits [i*DW +: DW].
- gnt  output  4  one-hot grant, registered.
- sel  output  2  index of the granted requester, registered; mux select.
- ack  output  4  one-cycle completion strobe to the granted requester.
- err  output  4  one-cycle timeout strobe to the granted requester.
- rdata  output  DW  mem_rdata passed through to all requesters.
- mem_valid  output  1  shared port request, high throughout BUSY.
- mem_we  output  1  we_in[sel] while BUSY, else 0.
- mem_addr  output  AW  addr_in selected by sel.
- mem_wdata  output  DW  wdata_in selected by sel.
- mem_rdata  input  DW  read data, valid when mem_ready=1.
- mem_ready  input  1  transaction complete.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0, sel=0, gnt=0, cnt=0, mem_valid=0. ack, err and mem_we are 0 because they are decoded from BUSY.
- Reset mid-transaction abandons the transaction: no ack or err is produced.
- IDLE, req==0: stay in IDLE. gnt and sel hold 0 / last value; sel is don't-care in IDLE.
- IDLE, req!=0: winner = first set bit scanning ptr, ptr+1, ... mod 4.
  - At the next edge: sel<=winner, gnt<=1<<winner, cnt<=0, state<=BUSY.
  - Grant latency is 1 clock from req sampled high.
- BUSY: mem_valid=1 and mem_we=we_in[sel].
  - mem_addr and mem_wdata are combinational muxes of the inputs by sel.
  - We_in, addr_in and wdata_in of the granted requester must be stable while it is granted.
- BUSY, mem_ready=1: ack[sel]=1 in the same cycle (combinational: BUSY & mem_ready); rdata=mem_rdata in that cycle.
  - Next edge: state<=IDLE, gnt<=0, ptr<=sel+1 (2-bit wrap, 3 wraps to 0).
- BUSY, mem_ready=0, TIMEOUT!=0, cnt==TIMEOUT-1: err[sel]=1 this cycle.
  - Next edge: state<=IDLE, gnt<=0, ptr<=sel+1.
- BUSY, mem_ready=0 and no timeout: cnt<=cnt+1. cnt width is clog2(TIMEOUT+1), minimum 1 bit.
- If mem_ready and the timeout coincide, mem_ready wins: ack only, no err.
- Requester protocol: req must drop in the cycle after ack/err unless the requester wants another transaction.
  - The arbiter always spends exactly one IDLE cycle between transactions, so the minimum issue rate is one transaction per 2 + wait cycles.
- req deasserted illegally during BUSY is ignored; the transaction still completes.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,...
  - Any requester waits at most 3 other transactions.
- gnt is always one-hot or zero; ack and err are never both set; at most one bit of each is set.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=1'b0, BUSY=1'b1);
  - NREQ=4;
  - the round-robin priority function (ptr, req -> winner index, found flag).
- Natural sub-module: the existing mux4_1, instantiated twice.
  - One instance with N=AW for mem_addr.
  - One instance with N=DW for mem_wdata.
  - Both with ctrl=sel.
- mem_we is an inline 4:1 bit select.
- FSM, ptr and cnt live in the top module.

Test Plan:
- Reset then req=4'b0100, mem_ready pulsed on the 3rd BUSY cycle -> gnt=0100 and sel=2 one cycle after req. mem_valid high 3 cycles; ack=0100 for exactly one cycle; next grant scan starts at ptr=3.
- req=4'b1111 held, mem_ready=1 every BUSY cycle -> grant order 0,1,2,3,0. One IDLE cycle between grants; each ack one cycle wide.
- ptr=3 after a grant to 2, req=4'b0011 -> requester 0 is granted, not 1 (wrap-around).
- TIMEOUT=4, req=0001, mem_ready held 0 -> err=0001 on the 4th BUSY cycle; no ack; IDLE next cycle; ptr=1.
- Grant requester 1 with addr_in[1]=32'hDEAD_BEEF, we_in[1]=1, wdata_in[1]=32'h1234_5678 -> mem_addr, mem_we and mem_wdata equal those values throughout BUSY. mem_rdata=32'hCAFE_0001 with mem_ready -> rdata matches.
- rst_n driven low mid-BUSY -> gnt, mem_valid and sel go 0 immediately (asynchronously); no ack/err. After release, req=0010 is granted normally from ptr=0.

Source files
------------

// File: rtl/mem_bus_arbiter4_pkg.sv
// Shared definitions for the four-way memory bus arbiter: state encoding,
// requester count and the round-robin winner selection.
package mem_bus_arbiter4_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Return the first requester set when scanning ptr, ptr+1, ... (mod 4).
  // The scan runs from the farthest offset down so the nearest hit is the
  // last one written and therefore wins.
  function automatic pick_t rr_pick(input logic [1:0] ptr, input logic [NREQ-1:0] req);
    pick_t      r;
    logic [1:0] k;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter4_mux4_1.sv
// Plain 4:1 N-bit select used to steer requester address and write data
// onto the shared port.
module mux4_1 #(
  parameter int N = 32
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  input  logic [1:0]   ctrl,
  output logic [N-1:0] y
);

  // Select one of the four inputs by ctrl.
  always_comb begin
    y = d0;
    case (ctrl)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter4.sv
// Round-robin arbiter sharing one memory port among four requesters.
// A grant is held until mem_ready or until the timeout counter expires;
// one IDLE cycle always separates consecutive transactions.
module mem_bus_arbiter4
  import mem_bus_arbiter4_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we_in,
  input  logic [NREQ*AW-1:0]   addr_in,
  input  logic [NREQ*DW-1:0]   wdata_in,
  output logic [NREQ-1:0]      gnt,
  output logic [1:0]           sel,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      err,
  output logic [DW-1:0]        rdata,
  output logic                 mem_valid,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 mem_ready
);

  // Counter must reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t          state_reg, state_next;
  logic [1:0]      ptr_reg, ptr_next;
  logic [1:0]      sel_reg, sel_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            done;
  logic            tmo;
  pick_t           pick;

  // State, pointer, grant and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      sel_reg   <= 2'd0;
      gnt_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      gnt_reg   <= gnt_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state: pick a winner in IDLE, finish on ready or timeout in BUSY.
  // mem_ready is tested first so it beats a coincident timeout.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    gnt_next   = gnt_reg;
    cnt_next   = cnt_reg;
    done       = 1'b0;
    tmo        = 1'b0;
    pick       = rr_pick(ptr_reg, req);
    case (state_reg)
      IDLE: begin
        if (pick.found) begin
          sel_next   = pick.idx;
          gnt_next   = NREQ'(1) << pick.idx;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          done       = 1'b1;
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = sel_reg + 2'd1;
        end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
          tmo        = 1'b1;
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = sel_reg + 2'd1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt       = gnt_reg;
  assign sel       = sel_reg;
  assign mem_valid = (state_reg == BUSY);
  assign mem_we    = (state_reg == BUSY) & we_in[sel_reg];
  assign rdata     = mem_rdata;

  // Completion and timeout strobes go only to the granted requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_strobe
    assign ack[gi] = done & (sel_reg == 2'(gi));
    assign err[gi] = tmo  & (sel_reg == 2'(gi));
  end

  mux4_1 #(.N(AW)) u_addr_mux (
    .d0   (addr_in[0*AW +: AW]),
    .d1   (addr_in[1*AW +: AW]),
    .d2   (addr_in[2*AW +: AW]),
    .d3   (addr_in[3*AW +: AW]),
    .ctrl (sel_reg),
    .y    (mem_addr)
  );

  mux4_1 #(.N(DW)) u_wdata_mux (
    .d0   (wdata_in[0*DW +: DW]),
    .d1   (wdata_in[1*DW +: DW]),
    .d2   (wdata_in[2*DW +: DW]),
    .d3   (wdata_in[3*DW +: DW]),
    .ctrl (sel_reg),
    .y    (mem_wdata)
  );

endmodule

// File: tb/tb_mem_bus_arbiter4.sv
// Directed bench for mem_bus_arbiter4 with TIMEOUT=4.
module tb_mem_bus_arbiter4;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [3:0]      we_in;
  logic [4*AW-1:0] addr_in;
  logic [4*DW-1:0] wdata_in;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic [3:0]      ack;
  logic [3:0]      err;
  logic [DW-1:0]   rdata;
  logic            mem_valid;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ready;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter4 #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we_in     (we_in),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .gnt       (gnt),
    .sel       (sel),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n     = 1'b0;
    req       = 4'b0000;
    we_in     = 4'b0010;
    addr_in   = {32'h3333_0003, 32'h2222_0002, 32'hDEAD_BEEF, 32'h0000_0000};
    wdata_in  = {32'h3000_0003, 32'h2000_0002, 32'h1234_5678, 32'h0000_0000};
    mem_rdata = 32'h0;
    mem_ready = 1'b0;

    // Reset state
    #23;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(mem_valid), 32'h0);
    chk("rst_ack_err", 32'({ack, err}), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single request from 2, ready on 3rd BUSY cycle
    req = 4'b0100; #1;
    chk("t1_idle_gnt", 32'(gnt), 32'h0);
    tick(); #1;
    chk("t1_gnt", 32'(gnt), 32'h4);
    chk("t1_sel", 32'(sel), 32'h2);
    chk("t1_valid1", 32'(mem_valid), 32'h1);
    chk("t1_ack_early", 32'(ack), 32'h0);
    chk("t1_we0", 32'(mem_we), 32'h0);
    tick(); #1;
    chk("t1_valid2", 32'(mem_valid), 32'h1);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0000_5A5A; #1;
    chk("t1_valid3", 32'(mem_valid), 32'h1);
    chk("t1_ack", 32'(ack), 32'h4);
    chk("t1_err", 32'(err), 32'h0);
    chk("t1_rdata", rdata, 32'h0000_5A5A);
    tick();
    mem_ready = 1'b0; req = 4'b0000; #1;
    chk("t1_done_valid", 32'(mem_valid), 32'h0);
    chk("t1_done_ack", 32'(ack), 32'h0);
    chk("t1_done_gnt", 32'(gnt), 32'h0);

    // Wrap-around: ptr=3, req=0011 -> requester 0
    req = 4'b0011;
    tick(); #1;
    chk("wrap_gnt", 32'(gnt), 32'h1);
    chk("wrap_sel", 32'(sel), 32'h0);
    mem_ready = 1'b1; #1;
    chk("wrap_ack", 32'(ack), 32'h1);
    tick();
    mem_ready = 1'b0; req = 4'b0000; #1;

    // Data path through requester 1 (ptr=1)
    req = 4'b0010;
    tick(); #1;
    chk("dat_gnt", 32'(gnt), 32'h2);
    chk("dat_addr1", mem_addr, 32'hDEAD_BEEF);
    chk("dat_we1", 32'(mem_we), 32'h1);
    chk("dat_wdata1", mem_wdata, 32'h1234_5678);
    tick(); #1;
    chk("dat_addr2", mem_addr, 32'hDEAD_BEEF);
    chk("dat_wdata2", mem_wdata, 32'h1234_5678);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001; #1;
    chk("dat_ack", 32'(ack), 32'h2);
    chk("dat_rdata", rdata, 32'hCAFE_0001);
    tick();
    mem_ready = 1'b0; req = 4'b0000; #1;
    chk("dat_idle_we", 32'(mem_we), 32'h0);

    // Timeout: ptr=2, req=0001 -> grant 0, err on 4th BUSY cycle
    req = 4'b0001;
    tick(); #1;
    chk("tmo_gnt", 32'(gnt), 32'h1);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("tmo_noerr%0d", c), 32'({ack, err}), 32'h0);
      tick(); #1;
    end
    chk("tmo_err", 32'(err), 32'h1);
    chk("tmo_noack", 32'(ack), 32'h0);
    tick();
    req = 4'b0000; #1;
    chk("tmo_idle_valid", 32'(mem_valid), 32'h0);
    chk("tmo_idle_err", 32'(err), 32'h0);

    // ptr=1, req=1000 -> grant 3; ready coincides with timeout -> ack wins
    req = 4'b1000;
    tick(); #1;
    chk("coin_gnt", 32'(gnt), 32'h8);
    tick(); tick(); tick();
    mem_ready = 1'b1; #1;
    chk("coin_ack", 32'(ack), 32'h8);
    chk("coin_err", 32'(err), 32'h0);
    tick();
    mem_ready = 1'b0; req = 4'b0000; #1;

    // Fairness: all requesting, ready every BUSY cycle (ptr=0)
    req = 4'b1111; mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(4'b0001 << order[k]));
      chk($sformatf("rr%0d_ack", k), 32'(ack), 32'(4'b0001 << order[k]));
      tick(); #1;
      chk($sformatf("rr%0d_gap", k), 32'({gnt, ack}), 32'h0);
    end
    req = 4'b0000; mem_ready = 1'b0;
    tick();

    // Reset mid-BUSY (ptr=1): grant 2, then async reset
    req = 4'b0100;
    tick(); #1;
    chk("arst_pre_gnt", 32'(gnt), 32'h4);
    #2 rst_n = 1'b0; #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_sel", 32'(sel), 32'h0);
    chk("arst_valid", 32'(mem_valid), 32'h0);
    chk("arst_ack_err", 32'({ack, err}), 32'h0);
    req = 4'b0000;
    tick();
    #3 rst_n = 1'b1;
    tick();
    req = 4'b0011;
    tick(); #1;
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    chk("post_rst_sel", 32'(sel), 32'h0);
    mem_ready = 1'b1; #1;
    chk("post_rst_ack", 32'(ack), 32'h1);
    tick();
    mem_ready = 1'b0; req = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
